// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer that sits between the EX/MEM
// pipeline register and data_memory.
//   SB_DEPTH   : number of buffered stores (power of two, >= 2)
//   SB_ADDR_W  : word address width
//   SB_DATA_W  : store/load data width
//   SB_PTR_W   : head/tail pointer width
//   sb_entry_t : one buffered store {addr, data}
package sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage side of the store buffer: the store request/accept handshake and
// the combinational load lookup.
//   master : MEM stage (drives st_* requests and ld_valid/ld_addr)
//   slave  : store buffer (returns st_ready, ld_data, ld_fwd)
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
);

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_fwd;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_data, ld_fwd
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_data, ld_fwd
  );

endinterface

// File: rtl/sb_fwd_match.sv
// Combinational age-ordered search of the occupied buffer entries for the
// youngest store whose address equals ld_addr.
//   entry_addr : address field of every slot
//   head/count : oldest slot and occupancy; only head..head+count-1 are live
//   ld_addr    : load word address
//   hit/idx    : a live entry matched; idx is the youngest such slot
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [PTR_W-1:0]  idx
);

  logic [PTR_W-1:0] slot;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the result is the entry nearest tail-1.
  always_comb begin
    hit  = 1'b0;
    idx  = head;
    slot = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (entry_addr[slot] == ld_addr)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and data_memory. Stores retire in
// one cycle into a circular buffer and drain on cycles where no load needs
// the memory port. Loads read memory combinationally, overridden by the
// youngest buffered store to the same address.
//   clk, reset      : clock, synchronous active-high reset of buffer state
//   sb              : MEM-stage store/load interface (slave side)
//   mem_address     : data_memory address
//   mem_write_data  : data_memory write data
//   e_write_mem     : data_memory write enable
//   mem_read_data   : data_memory read data
//   empty, count    : occupancy status for the hazard unit
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  store_buffer_if.slave          sb,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_write_data,
  output logic                   e_write_mem,
  input  logic [DATA_W-1:0]      mem_read_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              enq;
  logic              drain;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;

  assign empty       = (count == '0);
  assign sb.st_ready = (count != CNT_W'(DEPTH));
  assign enq         = sb.st_valid && sb.st_ready;
  // Reset gates the drain so a buffer discarded mid-drain never writes.
  assign drain       = !reset && !sb.ld_valid && !empty;

  // Memory port: a load always owns the port; otherwise drain the head.
  always_comb begin
    mem_address    = ent_addr[head];
    mem_write_data = ent_data[head];
    e_write_mem    = 1'b0;
    if (sb.ld_valid) begin
      mem_address = sb.ld_addr;
    end else if (drain) begin
      e_write_mem = 1'b1;
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .entry_addr (ent_addr),
    .head       (head),
    .count      (count),
    .ld_addr    (sb.ld_addr),
    .hit        (hit),
    .idx        (hit_idx)
  );

  assign sb.ld_fwd  = hit;
  assign sb.ld_data = hit ? ent_data[hit_idx] : mem_read_data;

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      case ({enq, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; only slots inside head..tail are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= sb.st_addr;
      ent_data[tail] <= sb.st_data;
    end
  end

endmodule
